lvds_rx_word_align: RTL

LVDS_RX_WORD_ALIGN -- requirements
Module: lvds_rx_word_align

---
 rtl/lvds_rx_align_pkg.sv | 32 +++
 rtl/lvds_rx_lane_align_fsm.sv | 139 +++++++++++++
 rtl/lvds_rx_word_align.sv | 73 +++++++
 3 files changed

// File: rtl/lvds_rx_align_pkg.sv
// ---------------------------------------------------------------------------
// lvds_rx_align_pkg
//
// Shared definitions for the LVDS receive word aligner:
//   - lane FSM state encoding (kept as fixed-width constants so the encoding
//     matches the legacy netlist state bits)
//   - counter widths used by every lane FSM
//   - width of the training-pattern parameter
// ---------------------------------------------------------------------------
package lvds_rx_align_pkg;

    // Counter widths for the per-lane training FSM.
    localparam int unsigned WAIT_CNT_W  = 4;
    localparam int unsigned MATCH_CNT_W = 8;
    localparam int unsigned SLIP_CNT_W  = 4;

    // Training pattern is carried at the widest supported lane ratio; narrower
    // ratios use only its low bits.
    localparam int unsigned TRAIN_PATTERN_W = 10;

    // Lane FSM state encoding.
    localparam int unsigned LANE_ST_W = 3;
    typedef logic [LANE_ST_W-1:0] lane_state_t;

    localparam lane_state_t ST_IDLE   = 3'd0;
    localparam lane_state_t ST_WAIT   = 3'd1;
    localparam lane_state_t ST_CHECK  = 3'd2;
    localparam lane_state_t ST_SLIP   = 3'd3;
    localparam lane_state_t ST_LOCKED = 3'd4;
    localparam lane_state_t ST_FAIL   = 3'd5;

endpackage : lvds_rx_align_pkg

// File: rtl/lvds_rx_lane_align_fsm.sv
// ---------------------------------------------------------------------------
// lvds_rx_lane_align_fsm
//
// Training FSM for one deserialised LVDS lane. After a start pulse the lane
// waits for the IOD to settle, then compares the registered lane word with
// the training pattern. A mismatch issues one bit-slip pulse and the cycle
// repeats; enough consecutive matches lock the lane, and running out of slips
// marks it failed. LOCKED and FAIL are sticky until the next start or reset.
//
// Ports:
//   clk_i         fabric clock, rising edge
//   arst_i        asynchronous active-high reset
//   start_i       one-cycle pulse, (re)starts training from any state
//   word_i        registered lane word under test
//   bit_slip_o    one-cycle slip request to the IOD lane
//   locked_o      lane aligned (registered)
//   fail_o        lane gave up after all slips (registered)
// ---------------------------------------------------------------------------
module lvds_rx_lane_align_fsm
    import lvds_rx_align_pkg::*;
#(
    parameter int unsigned                     RATIO         = 10,
    parameter logic [TRAIN_PATTERN_W-1:0]      TRAIN_PATTERN = 10'h3F8,
    parameter int unsigned                     MATCH_COUNT   = 8,
    parameter int unsigned                     SLIP_WAIT     = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic [RATIO-1:0] word_i,
    output logic             bit_slip_o,
    output logic             locked_o,
    output logic             fail_o
);

    localparam logic [RATIO-1:0]       PATTERN    = TRAIN_PATTERN[RATIO-1:0];
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST  = WAIT_CNT_W'(SLIP_WAIT - 1);
    localparam logic [MATCH_CNT_W-1:0] MATCH_LAST = MATCH_CNT_W'(MATCH_COUNT);
    localparam logic [SLIP_CNT_W-1:0]  SLIP_LAST  = SLIP_CNT_W'(RATIO);

    lane_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_q,  wait_d;
    logic [MATCH_CNT_W-1:0] match_q, match_d;
    logic [SLIP_CNT_W-1:0]  slip_q,  slip_d;
    logic                   bit_slip_q;
    logic                   locked_q;
    logic                   fail_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        match_d = match_q;
        slip_d  = slip_q;

        if (start_i) begin
            // Restart wins over every other transition, including LOCKED/FAIL.
            state_d = ST_WAIT;
            wait_d  = '0;
            match_d = '0;
            slip_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end

                ST_WAIT: begin
                    wait_d = wait_q + WAIT_CNT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (word_i == PATTERN) begin
                        match_d = match_q + MATCH_CNT_W'(1);
                        if (match_d == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = '0;
                        // Slip count saturates at RATIO: every bit position has
                        // been tried, so a further mismatch is terminal.
                        if (slip_q == SLIP_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_SLIP;
                        end
                    end
                end

                ST_SLIP: begin
                    slip_d  = slip_q + SLIP_CNT_W'(1);
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end

                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so each flag is a flop that
    // lines up exactly with the state it reports.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            match_q    <= '0;
            slip_q     <= '0;
            bit_slip_q <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            match_q    <= match_d;
            slip_q     <= slip_d;
            bit_slip_q <= (state_d == ST_SLIP);
            locked_q   <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    assign bit_slip_o = bit_slip_q;
    assign locked_o   = locked_q;
    assign fail_o     = fail_q;

endmodule : lvds_rx_lane_align_fsm

// File: rtl/lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// lvds_rx_word_align
//
// Word aligner for NUM_LANES deserialised LVDS lanes. Registers the IOD data
// once, runs an independent training FSM per lane on the registered words,
// and reduces the per-lane flags into all-locked / all-done status.
//
// Ports:
//   FAB_CLK       fabric clock, rising edge
//   ARST          asynchronous active-high reset
//   ALIGN_START   one-cycle pulse, (re)starts training on every lane
//   RX_DATA_IN    IOD words, lane n at [n*RATIO +: RATIO]
//   RX_BIT_SLIP   per-lane one-cycle bit-slip pulse to the IOD
//   RX_DATA_OUT   RX_DATA_IN delayed by one cycle
//   LANE_LOCKED   per-lane aligned flag
//   LANE_FAIL     per-lane training failed flag
//   ALL_LOCKED    every lane locked
//   ALIGN_DONE    every lane locked or failed
// ---------------------------------------------------------------------------
module lvds_rx_word_align
    import lvds_rx_align_pkg::*;
#(
    parameter int unsigned                NUM_LANES     = 4,
    parameter int unsigned                RATIO         = 10,
    parameter logic [TRAIN_PATTERN_W-1:0] TRAIN_PATTERN = 10'h3F8,
    parameter int unsigned                MATCH_COUNT   = 8,
    parameter int unsigned                SLIP_WAIT     = 4
) (
    input  logic                         FAB_CLK,
    input  logic                         ARST,
    input  logic                         ALIGN_START,
    input  logic [NUM_LANES*RATIO-1:0]   RX_DATA_IN,
    output logic [NUM_LANES-1:0]         RX_BIT_SLIP,
    output logic [NUM_LANES*RATIO-1:0]   RX_DATA_OUT,
    output logic [NUM_LANES-1:0]         LANE_LOCKED,
    output logic [NUM_LANES-1:0]         LANE_FAIL,
    output logic                         ALL_LOCKED,
    output logic                         ALIGN_DONE
);

    logic [NUM_LANES*RATIO-1:0] rx_data_q;

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            rx_data_q <= '0;
        end else begin
            rx_data_q <= RX_DATA_IN;
        end
    end

    assign RX_DATA_OUT = rx_data_q;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lvds_rx_lane_align_fsm #(
            .RATIO         (RATIO),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .MATCH_COUNT   (MATCH_COUNT),
            .SLIP_WAIT     (SLIP_WAIT)
        ) u_fsm (
            .clk_i      (FAB_CLK),
            .arst_i     (ARST),
            .start_i    (ALIGN_START),
            .word_i     (rx_data_q[n*RATIO +: RATIO]),
            .bit_slip_o (RX_BIT_SLIP[n]),
            .locked_o   (LANE_LOCKED[n]),
            .fail_o     (LANE_FAIL[n])
        );
    end

    assign ALL_LOCKED = &LANE_LOCKED;
    assign ALIGN_DONE = &(LANE_LOCKED | LANE_FAIL);

endmodule : lvds_rx_word_align
